revrange_deser_parity: RTL
==========================

REVRANGE_DESER_PARITY -- requirements
Module: revrange_deser_parity

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of data bits per frame (legal range 2..32).
REQ-002 SHALL have parameter PARITY_ODD, default 0, parity sense: 0 = even, 1 = odd.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port s_valid  input  1  serial bit present on s_data.
REQ-006 SHALL have port s_data  input  1  serial bit; data bits first, then one parity bit.
REQ-007 SHALL have port s_ready  output  1  block accepts a serial bit this cycle.
REQ-008 SHALL have port out_data  output  [0:WIDTH-1]  assembled word, ascending range; index 0 holds the first bit received.
REQ-009 SHALL have port out_valid  output  1  out_data and flags hold a complete frame.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the frame.
REQ-011 SHALL have port out_parity_err  output  1  frame parity mismatch.
REQ-012 SHALL have port out_and / out_or / out_xor  output  1 each  AND/OR/XOR reductions of out_data.

Function
REQ-013 SHALL implement FSM states COLLECT, PARITY, HOLD; a serial transfer occurs when s_valid && s_ready.
REQ-014 SHALL drive s_ready high in COLLECT and PARITY and low in HOLD; s_ready is a registered function of state only.
REQ-015 In COLLECT, each transfer SHALL write s_data into shift-register position cnt and increment cnt (0..WIDTH-1).
REQ-016 The transfer with cnt == WIDTH-1 SHALL move COLLECT -> PARITY and clear cnt.
REQ-017 In PARITY, the transfer SHALL capture the parity bit and move to HOLD.
REQ-018 On that same edge, out_data, out_parity_err and the reductions SHALL be loaded; out_valid SHALL rise the cycle after the parity bit is accepted (latency 1).
REQ-019 out_parity_err SHALL equal (XOR of all data bits XOR parity bit) != PARITY_ODD.
REQ-020 out_and / out_or / out_xor SHALL be computed over the captured WIDTH bits and registered with out_data.
REQ-021 In HOLD, out_valid && out_ready SHALL return the FSM to COLLECT and clear out_valid on the next edge.
REQ-022 In HOLD without out_ready, out_data, flags and out_valid SHALL remain stable indefinitely.
REQ-023 Cycles with s_valid low SHALL not change cnt, state or partial data (gaps allowed anywhere, including before parity).
REQ-024 Serial bits are never accepted in HOLD; back-to-back frames therefore need one idle serial cycle after each out_ready handshake.
REQ-025 out_data SHALL change only when a complete frame is loaded; partial frames stay internal.

Reset
REQ-026 Asserting rst SHALL immediately force state = COLLECT, cnt = 0 and the internal shift register to 0.
REQ-027 Asserting rst SHALL also force out_valid = 0, s_ready = 0, out_data = 0, out_parity_err = 0, out_and = 0, out_or = 0, out_xor = 0.
REQ-028 s_ready SHALL rise on the first clock edge after rst deasserts.
REQ-029 rst mid-frame or in HOLD SHALL discard the partial or pending frame; the next accepted bit is data bit 0.

Verification
REQ-030 WIDTH=8, even: bits 1,0,1,1,0,0,0,0 then parity 1 -> out_data[0:7]=10110000, err=0, and=0, or=1, xor=1, out_valid 1 cycle after parity.
REQ-031 Same data, parity 0 -> out_parity_err=1; repeat with PARITY_ODD=1 -> err=0.
REQ-032 All-ones data 11111111, parity 0 -> and=1, or=1, xor=0, err=0.
REQ-033 out_ready held low 10 cycles in HOLD with s_valid high -> s_ready=0, outputs stable, no bits consumed; out_ready pulse -> COLLECT, next frame captured correctly.
REQ-034 s_valid toggled randomly through a frame -> result identical to the gap-free frame.
REQ-035 rst asserted after 5 data bits, then a full frame 01010101 parity 0 -> out_data=01010101, err=0; no trace of the aborted bits.

Source files
------------

// File: rtl/revrange_deser_parity.sv
// Serial-to-parallel deserializer with trailing parity bit.
// Frames are WIDTH data bits (first bit lands in out_data[0]) followed by one
// parity bit. The completed frame, its parity check and reductions are held
// until the consumer accepts them.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting data bits into the shift register at index cnt
// PARITY  | all data bits captured, waiting for the parity bit
// HOLD    | frame presented on outputs, serial input stalled
module revrange_deser_parity #(
  parameter int WIDTH      = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic [0:WIDTH-1] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity_err,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor
);

  localparam int   CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic PAR_SENSE = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [0:WIDTH-1] shreg_q, shreg_d;
  logic [0:WIDTH-1] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             s_ready_q, s_ready_d;
  logic             err_q, err_d;
  logic             and_q, and_d;
  logic             or_q, or_d;
  logic             xor_q, xor_d;
  logic             xfer;

  assign xfer = s_valid && s_ready_q;

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    and_d       = and_q;
    or_d        = or_q;
    xor_d       = xor_q;
    case (state_q)
      COLLECT: begin
        if (xfer) begin
          shreg_d[cnt_q] = s_data;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        // Last data bit is already in shreg_q, so the whole word is available here.
        if (xfer) begin
          out_data_d  = shreg_q;
          err_d       = ((^shreg_q) ^ s_data) != PAR_SENSE;
          and_d       = &shreg_q;
          or_d        = |shreg_q;
          xor_d       = ^shreg_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    // Registered from next state so s_ready reflects the state it is paired with.
    s_ready_d = (state_d != HOLD);
  end

  // State and output registers; reset discards any partial or pending frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      shreg_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      s_ready_q   <= 1'b0;
      err_q       <= 1'b0;
      and_q       <= 1'b0;
      or_q        <= 1'b0;
      xor_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      s_ready_q   <= s_ready_d;
      err_q       <= err_d;
      and_q       <= and_d;
      or_q        <= or_d;
      xor_q       <= xor_d;
    end
  end

  assign s_ready        = s_ready_q;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign out_parity_err = err_q;
  assign out_and        = and_q;
  assign out_or         = or_q;
  assign out_xor        = xor_q;

endmodule
